// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet receive path.
//   - fifo control tokens (9-bit words, bit8 = control)
//   - preamble / SFD / VLAN TPID byte values
//   - frame controller state encoding
//   - mac_byte(): selects DA byte i (0 = first on the wire) from a station MAC
package eth_pkg;

  localparam logic [8:0] TOK_SOF = 9'h100;
  localparam logic [8:0] TOK_EOF = 9'h101;
  localparam logic [8:0] TOK_ERR = 9'h1FF;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hAB;
  localparam logic [7:0] VLAN_TPID_HI  = 8'h81;
  localparam logic [7:0] VLAN_TPID_LO  = 8'h00;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_ABORT    = 3'd4;
  localparam logic [2:0] ST_DROP     = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    PREAMBLE = ST_PREAMBLE,
    ADDR     = ST_ADDR,
    DATA     = ST_DATA,
    ABORT    = ST_ABORT,
    DROP     = ST_DROP
  } state_e;

  // MAC bits [47:40] are the first DA byte on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_rx_addr_filter.sv
// Destination-address filter. Tracks running unicast / broadcast match flags
// over DA bytes 0..5.
//   eth_rx_clk_in, rst : clock, async active-high reset
//   clear_in           : re-arm both flags (at SOF)
//   en_in              : a DA byte is being consumed this cycle
//   idx_in, d_in       : DA byte index and value
//   mac_addr_in        : station MAC
//   promisc_in         : accept any DA
//   accept_out         : match including the current byte (valid at idx 5)
module eth_rx_addr_filter
  import eth_pkg::*;
(
  input  logic        eth_rx_clk_in,
  input  logic        rst,
  input  logic        clear_in,
  input  logic        en_in,
  input  logic [2:0]  idx_in,
  input  logic [7:0]  d_in,
  input  logic [47:0] mac_addr_in,
  input  logic        promisc_in,
  output logic        accept_out
);

  logic ucast_q, bcast_q;
  logic ucast_hit, bcast_hit;

  // Hits fold in the byte on the input now, so accept is ready at byte 5.
  assign ucast_hit  = ucast_q & (d_in == mac_byte(mac_addr_in, idx_in));
  assign bcast_hit  = bcast_q & (d_in == 8'hFF);
  assign accept_out = ucast_hit | bcast_hit | promisc_in;

  always_ff @(posedge eth_rx_clk_in or posedge rst) begin
    if (rst) begin
      ucast_q <= 1'b1;
      bcast_q <= 1'b1;
    end else if (clear_in) begin
      ucast_q <= 1'b1;
      bcast_q <= 1'b1;
    end else if (en_in) begin
      ucast_q <= ucast_hit;
      bcast_q <= bcast_hit;
    end
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame admission controller: strips preamble, filters DA, enforces
// length limits and writes data words / SOF / EOF / ERR tokens into the RX
// fifo. Keeps saturating good / dropped frame counters.
// Optional build macro: ETH_RX_VLAN_EN (tagged frames get MAX_FRAME_LEN+4).
//   eth_rx_clk_in, rst            : clock, async active-high reset
//   eth_rx_d_in/dv_in/err_in      : PHY receive byte, valid, error
//   mac_addr_in, promisc_in       : address filter config
//   fifo_wr_en_out, fifo_wr_d_out : fifo write strobe / 9-bit word
//   fifo_full_in                  : fifo full
//   frames_ok_out, frames_drop_out: statistics
//   busy_out                      : state != IDLE
module eth_rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_W         = 16
) (
  input  logic             eth_rx_clk_in,
  input  logic             rst,
  input  logic [7:0]       eth_rx_d_in,
  input  logic             eth_rx_dv_in,
  input  logic             eth_rx_err_in,
  input  logic [47:0]      mac_addr_in,
  input  logic             promisc_in,
  output logic             fifo_wr_en_out,
  output logic [8:0]       fifo_wr_d_out,
  input  logic             fifo_full_in,
  output logic [CNT_W-1:0] frames_ok_out,
  output logic [CNT_W-1:0] frames_drop_out,
  output logic             busy_out
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

  state_e           state_q, state_d;
  logic [10:0]      cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [8:0]       wr_d_q, wr_d_d;
  logic [CNT_W-1:0] ok_q, ok_d, drop_q, drop_d;
  logic             eof_pend_q, eof_pend_d;
  logic             filt_clr, filt_en, accept;
  logic [10:0]      lim;

`ifdef ETH_RX_VLAN_EN
  logic tpid_hi_q, tpid_hi_d, vlan_q, vlan_d;
  assign lim = vlan_q ? 11'(MAX_FRAME_LEN + 4) : MAX_LEN;
`else
  assign lim = MAX_LEN;
`endif

  eth_rx_addr_filter u_filt (
    .eth_rx_clk_in (eth_rx_clk_in),
    .rst           (rst),
    .clear_in      (filt_clr),
    .en_in         (filt_en),
    .idx_in        (cnt_q[2:0]),
    .d_in          (eth_rx_d_in),
    .mac_addr_in   (mac_addr_in),
    .promisc_in    (promisc_in),
    .accept_out    (accept)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_d_d     = wr_d_q;
    ok_d       = ok_q;
    drop_d     = drop_q;
    eof_pend_d = eof_pend_q;
    filt_clr   = 1'b0;
    filt_en    = 1'b0;
`ifdef ETH_RX_VLAN_EN
    tpid_hi_d  = tpid_hi_q;
    vlan_d     = vlan_q;
`endif
    case (state_q)
      IDLE: begin
        if (eth_rx_dv_in && !eth_rx_err_in && eth_rx_d_in == PREAMBLE_BYTE)
          state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (eth_rx_err_in || !eth_rx_dv_in) begin
          state_d = DROP;
        end else if (eth_rx_d_in == PREAMBLE_BYTE) begin
          state_d = PREAMBLE;
        end else if (eth_rx_d_in == SFD_BYTE) begin
          if (!fifo_full_in) begin
            wr_en_d  = 1'b1;
            wr_d_d   = TOK_SOF;
            cnt_d    = '0;
            filt_clr = 1'b1;
`ifdef ETH_RX_VLAN_EN
            tpid_hi_d = 1'b0;
            vlan_d    = 1'b0;
`endif
            state_d  = ADDR;
          end else begin
            // Refused at SFD: counted as dropped, nothing reaches the fifo.
            drop_d  = (&drop_q) ? drop_q : drop_q + 1'b1;
            state_d = DROP;
          end
        end else begin
          state_d = DROP;
        end
      end
      ADDR: begin
        if (!eth_rx_dv_in || eth_rx_err_in || fifo_full_in) begin
          state_d = ABORT;
        end else begin
          wr_en_d = 1'b1;
          wr_d_d  = {1'b0, eth_rx_d_in};
          cnt_d   = cnt_q + 11'd1;
          filt_en = 1'b1;
          if (cnt_q == 11'd5)
            state_d = accept ? DATA : ABORT;
        end
      end
      DATA: begin
        if (eof_pend_q) begin
          // Frame already ended; only the deferred EOF remains.
          if (!fifo_full_in) begin
            wr_en_d    = 1'b1;
            wr_d_d     = TOK_EOF;
            ok_d       = (&ok_q) ? ok_q : ok_q + 1'b1;
            eof_pend_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (eth_rx_err_in) begin
          state_d = ABORT;
        end else if (eth_rx_dv_in) begin
          if (fifo_full_in || cnt_q >= lim) begin
            state_d = ABORT;
          end else begin
            wr_en_d = 1'b1;
            wr_d_d  = {1'b0, eth_rx_d_in};
            cnt_d   = cnt_q + 11'd1;
`ifdef ETH_RX_VLAN_EN
            if (cnt_q == 11'd12 && eth_rx_d_in == VLAN_TPID_HI)
              tpid_hi_d = 1'b1;
            if (cnt_q == 11'd13 && tpid_hi_q && eth_rx_d_in == VLAN_TPID_LO)
              vlan_d = 1'b1;
`endif
          end
        end else if (cnt_q < MIN_LEN) begin
          state_d = ABORT;
        end else if (fifo_full_in) begin
          eof_pend_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          wr_d_d  = TOK_EOF;
          ok_d    = (&ok_q) ? ok_q : ok_q + 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (!fifo_full_in) begin
          wr_en_d = 1'b1;
          wr_d_d  = TOK_ERR;
          drop_d  = (&drop_q) ? drop_q : drop_q + 1'b1;
          state_d = DROP;
        end
      end
      DROP: begin
        if (!eth_rx_dv_in && !eth_rx_err_in)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eth_rx_clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_d_q     <= '0;
      ok_q       <= '0;
      drop_q     <= '0;
      eof_pend_q <= 1'b0;
`ifdef ETH_RX_VLAN_EN
      tpid_hi_q  <= 1'b0;
      vlan_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_d_q     <= wr_d_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
      eof_pend_q <= eof_pend_d;
`ifdef ETH_RX_VLAN_EN
      tpid_hi_q  <= tpid_hi_d;
      vlan_q     <= vlan_d;
`endif
    end
  end

  assign fifo_wr_en_out  = wr_en_q;
  assign fifo_wr_d_out   = wr_d_q;
  assign frames_ok_out   = ok_q;
  assign frames_drop_out = drop_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl with a fifo-word scoreboard.
module tb_eth_rx_frame_ctrl;

  localparam logic [8:0] SOF = 9'h100;
  localparam logic [8:0] EOF = 9'h101;
  localparam logic [8:0] ERR = 9'h1FF;
  localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] BAD = 48'h02_11_22_33_44_56;

  logic        eth_rx_clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  d = 8'h00;
  logic        dv = 1'b0, err = 1'b0, full = 1'b0, promisc = 1'b0;
  logic        wr_en, busy;
  logic [8:0]  wr_d;
  logic [15:0] ok_cnt, drop_cnt;
  logic        full_smp = 1'b0;

  int nchk = 0, nfail = 0;
  int exp_ok = 0, exp_drop = 0;
  logic [8:0] q[$];

  always #5 eth_rx_clk_in = ~eth_rx_clk_in;

  eth_rx_frame_ctrl dut (
    .eth_rx_clk_in   (eth_rx_clk_in),
    .rst             (rst),
    .eth_rx_d_in     (d),
    .eth_rx_dv_in    (dv),
    .eth_rx_err_in   (err),
    .mac_addr_in     (MAC),
    .promisc_in      (promisc),
    .fifo_wr_en_out  (wr_en),
    .fifo_wr_d_out   (wr_d),
    .fifo_full_in    (full),
    .frames_ok_out   (ok_cnt),
    .frames_drop_out (drop_cnt),
    .busy_out        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full as seen by the DUT at the last rising edge
  always @(posedge eth_rx_clk_in) full_smp <= full;

  // Scoreboard: every fifo write must match the next expected word.
  always @(negedge eth_rx_clk_in) begin
    if (!rst && wr_en) begin
      chk("write_while_full", {31'd0, full_smp}, 32'd0);
      nchk++;
      assert (q.size() > 0) else begin
        nfail++;
        $error("FAIL unexpected_write: got %0h expected no write", wr_d);
      end
      if (q.size() > 0) chk("fifo_word", {23'd0, wr_d}, {23'd0, q.pop_front()});
    end
  end

  function automatic logic [7:0] fbyte(input logic [47:0] da, input int i, input bit vlan);
    if (i < 6) return da[47-8*i -: 8];
    if (vlan && i == 12) return 8'h81;
    if (vlan && i == 13) return 8'h00;
    return 8'(i) ^ 8'h5A;
  endfunction

  task automatic exp_frame(input logic [47:0] da, input int nbytes, input bit vlan, input int tail);
    q.push_back(SOF);
    for (int i = 0; i < nbytes; i++) q.push_back({1'b0, fbyte(da, i, vlan)});
    if (tail >= 0) q.push_back(9'(tail));
  endtask

  // Positions: 0..6 preamble, 7 SFD, 8+i frame byte i, then 6 idle cycles.
  task automatic drive_frame(input logic [47:0] da, input int len, input bit vlan,
                             input int err_pos, input int full_pos, input int full_len);
    for (int p = 0; p < 8 + len + 6; p++) begin
      @(posedge eth_rx_clk_in); #1;
      dv   = (p < 8 + len);
      d    = (p < 7) ? 8'hAA : (p == 7) ? 8'hAB : (p < 8 + len) ? fbyte(da, p - 8, vlan) : 8'h00;
      err  = (p == err_pos);
      full = (p >= full_pos) && (p < full_pos + full_len);
    end
    @(posedge eth_rx_clk_in); #1;
    dv = 1'b0; err = 1'b0; full = 1'b0;
  endtask

  task automatic settle(input string tag);
    for (int c = 0; c < 20 && q.size() > 0; c++) @(posedge eth_rx_clk_in);
    @(posedge eth_rx_clk_in); #2;
    chk({tag, "_pending"}, q.size(), 0);
    q.delete();
    chk({tag, "_ok"}, {16'd0, ok_cnt}, exp_ok);
    chk({tag, "_drop"}, {16'd0, drop_cnt}, exp_drop);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    repeat (3) @(posedge eth_rx_clk_in);
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_d", {23'd0, wr_d}, 0);
    chk("rst_ok", {16'd0, ok_cnt}, 0);
    chk("rst_drop", {16'd0, drop_cnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;

    // good unicast, broadcast, mismatched DA, promiscuous
    exp_frame(MAC, 64, 0, EOF); drive_frame(MAC, 64, 0, -1, -1, 0); exp_ok++;   settle("ucast64");
    exp_frame(BC, 64, 0, EOF);  drive_frame(BC, 64, 0, -1, -1, 0);  exp_ok++;   settle("bcast64");
    exp_frame(BAD, 6, 0, ERR);  drive_frame(BAD, 64, 0, -1, -1, 0); exp_drop++; settle("da_miss");
    promisc = 1'b1;
    exp_frame(BAD, 64, 0, EOF); drive_frame(BAD, 64, 0, -1, -1, 0); exp_ok++;   settle("promisc");
    promisc = 1'b0;

    // length limits
    exp_frame(MAC, 60, 0, ERR);   drive_frame(MAC, 60, 0, -1, -1, 0);   exp_drop++; settle("runt60");
    exp_frame(MAC, 1518, 0, EOF); drive_frame(MAC, 1518, 0, -1, -1, 0); exp_ok++;   settle("max1518");
    exp_frame(MAC, 1518, 0, ERR); drive_frame(MAC, 1525, 0, -1, -1, 0); exp_drop++; settle("long1525");

    // fifo full: mid-data, at SFD, at end of frame (EOF deferred)
    exp_frame(MAC, 30, 0, ERR);   drive_frame(MAC, 64, 0, -1, 8 + 30, 3); exp_drop++; settle("full_mid");
    drive_frame(MAC, 64, 0, -1, 7, 1); exp_drop++; settle("full_sfd");
    exp_frame(MAC, 64, 0, EOF);   drive_frame(MAC, 64, 0, -1, 8 + 64, 2); exp_ok++;   settle("full_eof");

    // receive error at byte 20
    exp_frame(MAC, 20, 0, ERR);   drive_frame(MAC, 64, 0, 8 + 20, -1, 0); exp_drop++; settle("rx_err");

    // VLAN-tagged length limit
`ifdef ETH_RX_VLAN_EN
    exp_frame(MAC, 1522, 1, EOF); drive_frame(MAC, 1522, 1, -1, -1, 0); exp_ok++; settle("vlan1522");
`else
    exp_frame(MAC, 1518, 1, ERR); drive_frame(MAC, 1522, 1, -1, -1, 0); exp_drop++; settle("vlan1522");
`endif
    exp_frame(MAC, 1518, 0, ERR); drive_frame(MAC, 1522, 0, -1, -1, 0); exp_drop++; settle("untag1522");

    // reset mid-frame: byte 29's write is wiped by the async reset
    exp_frame(MAC, 29, 0, -1);
    for (int p = 0; p < 8 + 64; p++) begin
      @(posedge eth_rx_clk_in); #1;
      if (p == 8 + 30) begin
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", {31'd0, wr_en}, 0);
        chk("midrst_wr_d", {23'd0, wr_d}, 0);
        chk("midrst_ok", {16'd0, ok_cnt}, 0);
        chk("midrst_drop", {16'd0, drop_cnt}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
      end
      if (p == 8 + 32) rst = 1'b0;
      dv = 1'b1;
      d  = (p < 7) ? 8'hAA : (p == 7) ? 8'hAB : fbyte(MAC, p - 8, 0);
    end
    @(posedge eth_rx_clk_in); #1;
    dv = 1'b0;
    exp_ok = 0; exp_drop = 0;
    settle("mid_reset");

    exp_frame(MAC, 64, 0, EOF); drive_frame(MAC, 64, 0, -1, -1, 0); exp_ok++; settle("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
